// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator for the HDMI/VGA output path. A runtime-selectable
//   preset (640x480, 1024x768, 1920x1080) drives the h/v counters. Mode changes
//   are accepted by a small request FSM and take effect only at a frame
//   boundary, or immediately while the raster is disabled, so frames never tear.
// Ports
//   pixel_clock_i  : sole clock, rising edge
//   reset_i        : synchronous active-high reset
//   enable_i       : 1 = run raster, 0 = counters held at 0, outputs inactive
//   mode_sel_i     : requested preset, sampled with mode_load_i
//   mode_load_i    : one-cycle mode change request
//   mode_busy_o    : request accepted, waiting for the frame boundary
//   mode_err_o     : one-cycle pulse for a request with the reserved selector 3
//   cur_mode_o     : preset currently driving the timing
//   hsync_o/vsync_o: syncs, polarity from the preset
//   de_o, x_o, y_o : active-video flag and pixel coordinates (0 outside active)
//   line_start_o   : pulse on h=0
//   frame_start_o  : pulse on h=0, v=0
module video_timing_gen #(
   parameter int          CW           = 12,
   parameter logic [1:0]  DEFAULT_MODE = 2'd0
) (
   input  logic          pixel_clock_i,
   input  logic          reset_i,
   input  logic          enable_i,
   input  logic [1:0]    mode_sel_i,
   input  logic          mode_load_i,
   output logic          mode_busy_o,
   output logic          mode_err_o,
   output logic [1:0]    cur_mode_o,
   output logic          hsync_o,
   output logic          vsync_o,
   output logic          de_o,
   output logic [CW-1:0] x_o,
   output logic [CW-1:0] y_o,
   output logic          line_start_o,
   output logic          frame_start_o
);

   typedef struct packed {
      logic [CW-1:0] hslen, hbp, hres, hfp;
      logic [CW-1:0] vslen, vbp, vres, vfp;
      logic          pos;   // 1 = sync asserted high
   } timing_t;

   typedef enum logic {IDLE, PENDING} state_t;

   function automatic timing_t preset(input logic [1:0] m);
      timing_t t;
      case (m)
         2'd1: begin
            t.hslen = CW'(136); t.hbp = CW'(160); t.hres = CW'(1024); t.hfp = CW'(24);
            t.vslen = CW'(6);   t.vbp = CW'(29);  t.vres = CW'(768);  t.vfp = CW'(3);
            t.pos   = 1'b0;
         end
         2'd2: begin
            t.hslen = CW'(44);  t.hbp = CW'(148); t.hres = CW'(1920); t.hfp = CW'(88);
            t.vslen = CW'(5);   t.vbp = CW'(36);  t.vres = CW'(1080); t.vfp = CW'(4);
            t.pos   = 1'b1;
         end
         default: begin
            t.hslen = CW'(96);  t.hbp = CW'(48);  t.hres = CW'(640);  t.hfp = CW'(16);
            t.vslen = CW'(2);   t.vbp = CW'(33);  t.vres = CW'(480);  t.vfp = CW'(10);
            t.pos   = 1'b0;
         end
      endcase
      return t;
   endfunction

   state_t        state_q, state_d;
   logic [1:0]    cur_mode_q, cur_mode_d;
   logic [1:0]    lat_q, lat_d;
   logic [CW-1:0] h_q, h_d, v_q, v_d;
   logic          err_q, err_d;
   logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
   logic [CW-1:0] x_q, x_d, y_q, y_d;

   timing_t       tm, def_t;
   logic [CW-1:0] htot_m1, vtot_m1, hstart, vstart;
   logic          last_pix, boundary, load_ok, h_act, v_act;
   logic [1:0]    sel_next;

   assign def_t = preset(DEFAULT_MODE);

   always_comb begin
      tm       = preset(cur_mode_q);
      htot_m1  = tm.hslen + tm.hbp + tm.hres + tm.hfp - CW'(1);
      vtot_m1  = tm.vslen + tm.vbp + tm.vres + tm.vfp - CW'(1);
      hstart   = tm.hslen + tm.hbp;
      vstart   = tm.vslen + tm.vbp;
      last_pix = (h_q == htot_m1) && (v_q == vtot_m1);
      // With the raster stopped every cycle counts as a frame boundary.
      boundary = !enable_i || last_pix;
      load_ok  = mode_load_i && (mode_sel_i != 2'd3);
      // A request arriving on the boundary cycle wins over the latched one.
      sel_next = load_ok ? mode_sel_i : lat_q;

      state_d    = state_q;
      lat_d      = lat_q;
      cur_mode_d = cur_mode_q;
      err_d      = mode_load_i && (mode_sel_i == 2'd3);

      case (state_q)
         IDLE: begin
            if (load_ok) begin
               lat_d = mode_sel_i;
               if (boundary) cur_mode_d = mode_sel_i;
               else          state_d    = PENDING;
            end
         end
         PENDING: begin
            lat_d = sel_next;
            if (boundary) begin
               cur_mode_d = sel_next;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Counters run on the current mode's totals; the new mode starts at 0,0.
      h_d = '0;
      v_d = '0;
      if (enable_i) begin
         if (h_q == htot_m1) begin
            h_d = '0;
            v_d = (v_q == vtot_m1) ? '0 : v_q + CW'(1);
         end else begin
            h_d = h_q + CW'(1);
            v_d = v_q;
         end
      end

      // Output stage: decode of the current counter state, registered below.
      h_act = (h_q >= hstart) && (h_q < hstart + tm.hres);
      v_act = (v_q >= vstart) && (v_q < vstart + tm.vres);
      de_d  = enable_i && h_act && v_act;
      x_d   = de_d ? h_q - hstart : '0;
      y_d   = de_d ? v_q - vstart : '0;
      // Active level equals the polarity bit, hence the XNOR.
      hs_d  = enable_i ? ((h_q < tm.hslen) ~^ tm.pos) : ~tm.pos;
      vs_d  = enable_i ? ((v_q < tm.vslen) ~^ tm.pos) : ~tm.pos;
      ls_d  = enable_i && (h_q == '0);
      fs_d  = ls_d && (v_q == '0);
   end

   always_ff @(posedge pixel_clock_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         cur_mode_q <= DEFAULT_MODE;
         lat_q      <= DEFAULT_MODE;
         h_q        <= '0;
         v_q        <= '0;
         err_q      <= 1'b0;
         hs_q       <= ~def_t.pos;
         vs_q       <= ~def_t.pos;
         de_q       <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         ls_q       <= 1'b0;
         fs_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_mode_q <= cur_mode_d;
         lat_q      <= lat_d;
         h_q        <= h_d;
         v_q        <= v_d;
         err_q      <= err_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         de_q       <= de_d;
         x_q        <= x_d;
         y_q        <= y_d;
         ls_q       <= ls_d;
         fs_q       <= fs_d;
      end
   end

   assign mode_busy_o   = (state_q == PENDING);
   assign mode_err_o    = err_q;
   assign cur_mode_o    = cur_mode_q;
   assign hsync_o       = hs_q;
   assign vsync_o       = vs_q;
   assign de_o          = de_q;
   assign x_o           = x_q;
   assign y_o           = y_q;
   assign line_start_o  = ls_q;
   assign frame_start_o = fs_q;

endmodule
